// File: rtl/bcd_to_bin_time.sv
// rtl/bcd_to_bin_time.sv - two-digit BCD to binary converter for the time-set path.
// Optional build macro BCD_TO_BIN_SAT_EN: saturate range errors to MAX_VAL instead of flagging them.
module bcd_to_bin_time #(
  parameter int MAX_VAL = 59,
  parameter int OUT_W   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_tens,
  input  logic [3:0]       in_units,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_bin,
  output logic             out_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL8,
    ST_MUL2,
    ST_ADDU,
    ST_CHK,
    ST_OUT
  } state_t;

  localparam logic [6:0]       MAX_ACC = 7'(MAX_VAL);
  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_VAL);

  state_t           state_q, state_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       units_q, units_d;
  logic             dig_err_q, dig_err_d;
  logic [6:0]       acc_q, acc_d;
  logic [OUT_W-1:0] out_bin_q, out_bin_d;
  logic             out_err_q, out_err_d;
  logic             rng_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tens_q    <= 4'd0;
      units_q   <= 4'd0;
      dig_err_q <= 1'b0;
      acc_q     <= 7'd0;
      out_bin_q <= '0;
      out_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tens_q    <= tens_d;
      units_q   <= units_d;
      dig_err_q <= dig_err_d;
      acc_q     <= acc_d;
      out_bin_q <= out_bin_d;
      out_err_q <= out_err_d;
    end
  end

  assign rng_err = (acc_q > MAX_ACC);

  // tens*10 is built as (tens<<3)+(tens<<1); bad digits still walk the same path so timing never varies.
  always_comb begin
    state_d   = state_q;
    tens_d    = tens_q;
    units_d   = units_q;
    dig_err_d = dig_err_q;
    acc_d     = acc_q;
    out_bin_d = out_bin_q;
    out_err_d = out_err_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          tens_d    = in_tens;
          units_d   = in_units;
          dig_err_d = (in_tens > 4'd9) || (in_units > 4'd9);
          state_d   = ST_MUL8;
        end
      end
      ST_MUL8: begin
        acc_d   = {tens_q, 3'b000};
        state_d = ST_MUL2;
      end
      ST_MUL2: begin
        acc_d   = acc_q + {2'b00, tens_q, 1'b0};
        state_d = ST_ADDU;
      end
      ST_ADDU: begin
        acc_d   = acc_q + {3'b000, units_q};
        state_d = ST_CHK;
      end
      ST_CHK: begin
        if (dig_err_q) begin
          out_bin_d = '0;
          out_err_d = 1'b1;
        end else if (rng_err) begin
`ifdef BCD_TO_BIN_SAT_EN
          out_bin_d = MAX_OUT;
          out_err_d = 1'b0;
`else
          out_bin_d = '0;
          out_err_d = 1'b1;
`endif
        end else begin
          out_bin_d = acc_q[OUT_W-1:0];
          out_err_d = 1'b0;
        end
        state_d = ST_OUT;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign out_bin = out_bin_q;
  assign out_err = out_err_q;

endmodule

// File: tb/tb_bcd_to_bin_time.sv
// tb/tb_bcd_to_bin_time.sv - directed and random checks of bcd_to_bin_time (MAX_VAL 59 and 23).
module tb_bcd_to_bin_time;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_tens;
  logic [3:0] in_units;
  logic       out_ready;

  logic       in_ready59, out_valid59, out_err59;
  logic [5:0] out_bin59;
  logic       in_ready23, out_valid23, out_err23;
  logic [4:0] out_bin23;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_to_bin_time #(.MAX_VAL(59), .OUT_W(6)) dut59 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready59),
    .in_tens(in_tens), .in_units(in_units), .out_valid(out_valid59),
    .out_ready(out_ready), .out_bin(out_bin59), .out_err(out_err59)
  );

  bcd_to_bin_time #(.MAX_VAL(23), .OUT_W(5)) dut23 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready23),
    .in_tens(in_tens), .in_units(in_units), .out_valid(out_valid23),
    .out_ready(out_ready), .out_bin(out_bin23), .out_err(out_err23)
  );

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input int t, input int u, input int maxv,
                                output int b, output int e);
    int v;
    v = t * 10 + u;
    if (t > 9 || u > 9) begin
      b = 0; e = 1;
    end else if (v > maxv) begin
`ifdef BCD_TO_BIN_SAT_EN
      b = maxv; e = 0;
`else
      b = 0; e = 1;
`endif
    end else begin
      b = v; e = 0;
    end
  endfunction

  // Present a pair from a negedge and return at the negedge right after the accepting edge.
  task automatic start(input int t, input int u);
    int k;
    in_tens  = 4'(t);
    in_units = 4'(u);
    in_valid = 1'b1;
    k = 0;
    while (!in_ready59 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("accept_wait", int'(k < 20), 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic convert(input int t, input int u, input int hold);
    int k, b59, e59, b23, e23;
    model(t, u, 59, b59, e59);
    model(t, u, 23, b23, e23);
    start(t, u);
    k = 0;
    while (!out_valid59 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("latency", k, 4);
    check("valid23", out_valid23, 1);
    check("bin59", out_bin59, b59);
    check("err59", out_err59, e59);
    check("bin23", out_bin23, b23);
    check("err23", out_err23, e23);
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", out_valid59, 1);
      check("hold_bin", out_bin59, b59);
      check("hold_err", out_err59, e59);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("drop_valid", out_valid59, 0);
    check("ready_back", in_ready59, 1);
    check("ready_back23", in_ready23, 1);
  endtask

  initial begin
    int k, n, seen, t, u;
    bit acc_now;
    int res[$];

    rst_n = 1'b0; in_valid = 1'b0; in_tens = 4'd0; in_units = 4'd0; out_ready = 1'b0;
    #1;
    check("rst_ready", in_ready59, 1);
    check("rst_valid", out_valid59, 0);
    check("rst_bin", out_bin59, 0);
    check("rst_err", out_err59, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    convert(4, 7, 3);
    convert(0, 0, 0);
    convert(5, 9, 1);
    convert(6, 0, 0);
    convert(2, 10, 0);
    convert(2, 3, 0);
    convert(2, 4, 2);
    convert(9, 9, 0);
    convert(15, 15, 0);

    // Asynchronous reset while a result is pending on the output.
    start(5, 8);
    k = 0;
    while (!out_valid59 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("pre_rst_valid", out_valid59, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", in_ready59, 1);
    check("arst_valid", out_valid59, 0);
    check("arst_bin", out_bin59, 0);
    check("arst_err", out_err59, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset while in MUL2 discards the conversion.
    start(7, 7);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid59) seen = 1;
    end
    check("abort_no_valid", seen, 0);
    convert(0, 9, 0);

    // Back-to-back with in_valid held high.
    n = 0;
    in_tens = 4'd1; in_units = 4'd2; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      acc_now = in_valid && in_ready59;
      if (out_valid59) res.push_back(int'(out_bin59));
      @(negedge clk);
      if (acc_now) begin
        n++;
        if (n == 1) begin in_tens = 4'd3; in_units = 4'd4; end
        else in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    check("b2b_accepts", n, 2);
    check("b2b_results", res.size(), 2);
    if (res.size() == 2) begin
      check("b2b_first", res[0], 12);
      check("b2b_second", res[1], 34);
    end

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        t = $urandom_range(0, 15);
        u = $urandom_range(0, 15);
      end else begin
        t = $urandom_range(0, 9);
        u = $urandom_range(0, 9);
      end
      convert(t, u, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
